// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares a 4-cycle-latency main memory between I and D cache fill controllers.
// Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking instead of fixed D priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic        mem_data_valid,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        i_grant,
  output logic        d_grant,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic [2:0]  word_idx,
  output logic        i_done,
  output logic        d_done
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;          // 1 = D side owns the transaction
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  ret_cnt_q, ret_cnt_d;
  logic        issue_done_q, issue_done_d;
  logic        done_q, done_d;

  logic i_act, d_act, pick_d, pick_wr;
  logic [15:0] pick_addr;

  // The requester that just completed sits out its own done cycle.
  assign i_act = i_req && !(done_q && !owner_q);
  assign d_act = d_req && !(done_q && owner_q);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;
  assign pick_d = d_act && (!i_act || !last_d_q);
`else
  assign pick_d = d_act;
`endif

  assign pick_wr   = pick_d ? d_wr : i_wr;
  assign pick_addr = pick_d ? d_addr : i_addr;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    issue_done_d = issue_done_q;
    done_d       = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d_d     = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_act || d_act) begin
          owner_d      = pick_d;
          wdata_d      = pick_d ? d_wdata : i_wdata;
          issue_cnt_d  = 3'd0;
          ret_cnt_d    = 3'd0;
          issue_done_d = 1'b0;
          if (pick_wr) begin
            state_d = WRITE;
            addr_d  = {pick_addr[15:1], 1'b0};
          end else begin
            state_d = FILL;
            addr_d  = {pick_addr[15:4], 4'h0};
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d_d = pick_d;
`endif
        end
      end
      FILL: begin
        if (!issue_done_q) begin
          issue_cnt_d = issue_cnt_q + 3'd1;
          if (issue_cnt_q == 3'd7) issue_done_d = 1'b1;
        end
        if (mem_data_valid) begin
          ret_cnt_d = ret_cnt_q + 3'd1;
          if (ret_cnt_q == 3'd7) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      issue_cnt_q  <= 3'd0;
      ret_cnt_q    <= 3'd0;
      issue_done_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      issue_cnt_q  <= issue_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      issue_done_q <= issue_done_d;
      done_q       <= done_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_d_q <= 1'b1;
    else        last_d_q <= last_d_d;
  end
`endif

  logic fill_issue, in_fill, busy;
  assign in_fill    = (state_q == FILL);
  assign fill_issue = in_fill && !issue_done_q;
  assign busy       = (state_q != IDLE);

  assign mem_enable   = fill_issue || (state_q == WRITE);
  assign mem_wr       = (state_q == WRITE);
  assign mem_addr     = fill_issue ? (addr_q + {12'd0, issue_cnt_q, 1'b0}) :
                        (state_q == WRITE) ? addr_q : 16'h0000;
  assign mem_wdata    = (state_q == WRITE) ? wdata_q : 16'h0000;
  assign i_grant      = busy && !owner_q;
  assign d_grant      = busy && owner_q;
  assign i_data_valid = mem_data_valid && in_fill && !owner_q;
  assign d_data_valid = mem_data_valid && in_fill && owner_q;
  assign word_idx     = ret_cnt_q;
  assign i_done       = done_q && !owner_q;
  assign d_done       = done_q && owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a 4-cycle memory model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic i_req, i_wr, d_req, d_wr;
  logic [15:0] i_addr, i_wdata, d_addr, d_wdata;
  logic mem_data_valid;
  logic mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic i_grant, d_grant, i_data_valid, d_data_valid, i_done, d_done;
  logic [2:0] word_idx;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_data_valid(mem_data_valid),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .i_grant(i_grant), .d_grant(d_grant),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .word_idx(word_idx), .i_done(i_done), .d_done(d_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: each read issue returns a strobe 4 cycles later, independent of DUT reset.
  logic [3:0] hist = 4'b0;
  logic issue_s = 1'b0;
  always @(negedge clk) issue_s = mem_enable & ~mem_wr;
  always @(posedge clk) hist <= {hist[2:0], issue_s};
  assign mem_data_valid = hist[3];

  typedef struct {
    int          cyc;
    int          side;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  ev_t q_grant[$];
  ev_t q_mem[$];
  ev_t q_dv[$];
  ev_t q_done[$];

  int checks = 0;
  int errors = 0;

  task automatic cmp_ev(input string name, input bit have, input ev_t e, input ev_t a);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s unexpected: cyc=%0d side=%0d wr=%0d addr=%h data=%h", name, a.cyc, a.side, a.wr, a.addr, a.data);
    end else if (e.cyc != a.cyc || e.side != a.side || e.wr !== a.wr || e.addr !== a.addr || e.data !== a.data) begin
      errors++;
      $display("FAIL %s got cyc=%0d side=%0d wr=%0d addr=%h data=%h expected cyc=%0d side=%0d wr=%0d addr=%h data=%h",
               name, a.cyc, a.side, a.wr, a.addr, a.data, e.cyc, e.side, e.wr, e.addr, e.data);
    end
  endtask

  function automatic ev_t mk(input int c, input int s, input logic w, input logic [15:0] ad, input logic [15:0] dt);
    ev_t e;
    e.cyc = c; e.side = s; e.wr = w; e.addr = ad; e.data = dt;
    return e;
  endfunction

  // Monitor: pops the expected event whenever the DUT presents one.
  logic pi_g = 1'b0, pd_g = 1'b0;
  always @(negedge clk) begin : mon
    ev_t e, a;
    bit h;
    if ((i_grant && !pi_g) || (d_grant && !pd_g)) begin
      a = mk(cyc, d_grant ? 1 : 0, 1'b0, 16'h0, 16'h0);
      h = q_grant.size() > 0; if (h) e = q_grant.pop_front();
      cmp_ev("grant", h, e, a);
    end
    pi_g = i_grant; pd_g = d_grant;
    if (mem_enable) begin
      a = mk(cyc, 0, mem_wr, mem_addr, mem_wr ? mem_wdata : 16'h0);
      h = q_mem.size() > 0; if (h) e = q_mem.pop_front();
      cmp_ev("mem_access", h, e, a);
    end
    if (i_data_valid || d_data_valid) begin
      a = mk(cyc, (i_data_valid && d_data_valid) ? 2 : (d_data_valid ? 1 : 0), 1'b0, 16'h0, {13'd0, word_idx});
      h = q_dv.size() > 0; if (h) e = q_dv.pop_front();
      cmp_ev("data_valid", h, e, a);
    end
    if (i_done || d_done) begin
      a = mk(cyc, (i_done && d_done) ? 2 : (d_done ? 1 : 0), 1'b0, 16'h0, 16'h0);
      h = q_done.size() > 0; if (h) e = q_done.pop_front();
      cmp_ev("done", h, e, a);
    end
  end

  task automatic expect_fill(input int side, input logic [15:0] addr, input int g);
    logic [15:0] base;
    base = addr & 16'hFFF0;
    q_grant.push_back(mk(g, side, 1'b0, 16'h0, 16'h0));
    for (int k = 0; k < 8; k++) begin
      q_mem.push_back(mk(g + k, 0, 1'b0, base + 16'(2 * k), 16'h0));
      q_dv.push_back(mk(g + 4 + k, side, 1'b0, 16'h0, 16'(k)));
    end
    q_done.push_back(mk(g + 12, side, 1'b0, 16'h0, 16'h0));
  endtask

  task automatic expect_write(input int side, input logic [15:0] addr, input logic [15:0] data, input int g);
    q_grant.push_back(mk(g, side, 1'b0, 16'h0, 16'h0));
    q_mem.push_back(mk(g, 0, 1'b1, addr, data));
    q_done.push_back(mk(g + 1, side, 1'b0, 16'h0, 16'h0));
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_outputs_zero(input string name);
    logic [57:0] v;
    v = {mem_enable, mem_wr, mem_addr, mem_wdata, i_grant, d_grant,
         i_data_valid, d_data_valid, word_idx, i_done, d_done};
    checks++;
    if (v !== 58'd0) begin
      errors++;
      $display("FAIL %s outputs=%h expected all zero", name, v);
    end
  endtask

  task automatic check_empty(input string name, input int n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL %s leftover expected events=%0d required 0", name, n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  int t0;
  initial begin
    rst_n = 1'b0;
    i_req = 0; i_wr = 0; i_addr = 0; i_wdata = 0;
    d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("post_reset_idle");

    // Simultaneous fills straight after reset.
    t0 = cyc;
    i_req = 1; i_wr = 0; i_addr = 16'h2000;
    d_req = 1; d_wr = 0; d_addr = 16'h3018;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    expect_fill(0, 16'h2000, t0 + 1);
    expect_fill(1, 16'h3018, t0 + 14);
    wait_until(t0 + 13); i_req = 0;
    wait_until(t0 + 26); d_req = 0;
`else
    expect_fill(1, 16'h3018, t0 + 1);
    expect_fill(0, 16'h2000, t0 + 14);
    wait_until(t0 + 13); d_req = 0;
    wait_until(t0 + 26); i_req = 0;
`endif
    wait_until(t0 + 28);

    // Single I fill from an unaligned address.
    t0 = cyc;
    i_req = 1; i_addr = 16'h1236;
    expect_fill(0, 16'h1236, t0 + 1);
    wait_until(t0 + 13); i_req = 0;
    wait_until(t0 + 15);

    // D write-through store.
    t0 = cyc;
    d_req = 1; d_wr = 1; d_addr = 16'h4001; d_wdata = 16'hBEEF;
    expect_write(1, 16'h4000, 16'hBEEF, t0 + 1);
    wait_until(t0 + 2); d_req = 0; d_wr = 0;
    wait_until(t0 + 4);

    // Back-to-back I fills with the request held through the done cycle.
    t0 = cyc;
    i_req = 1; i_addr = 16'h0040;
    expect_fill(0, 16'h0040, t0 + 1);
    expect_fill(0, 16'h0082, t0 + 15);
    wait_until(t0 + 13); i_addr = 16'h0082;
    wait_until(t0 + 27); i_req = 0;
    wait_until(t0 + 29);

    // Fill at the top of the address space.
    t0 = cyc;
    i_req = 1; i_addr = 16'hFFF8;
    expect_fill(0, 16'hFFF8, t0 + 1);
    wait_until(t0 + 13); i_req = 0;
    wait_until(t0 + 15);

    // Reset in the middle of an I fill; stray returns must be dropped.
    t0 = cyc;
    i_req = 1; i_addr = 16'h5550;
    expect_fill(0, 16'h5550, t0 + 1);
    wait_until(t0 + 6);
    rst_n = 1'b0; i_req = 0;
    #1;
    check_outputs_zero("async_reset_mid_fill");
    q_mem.delete(); q_dv.delete(); q_done.delete();
    wait_until(t0 + 7); rst_n = 1'b1;
    wait_until(t0 + 12);
    d_req = 1; d_wr = 1; d_addr = 16'h6002; d_wdata = 16'h1234;
    expect_write(1, 16'h6002, 16'h1234, t0 + 13);
    wait_until(t0 + 14); d_req = 0; d_wr = 0;
    wait_until(t0 + 17);

    check_empty("grant_queue", q_grant.size());
    check_empty("mem_queue", q_mem.size());
    check_empty("data_valid_queue", q_dv.size());
    check_empty("done_queue", q_done.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single pipelined main memory (16-bit words, fixed 4-cycle read latency) between the I-cache and D-cache fill controllers. Each requester asks for either an 8-word block fill or a single-word write-through store. The arbiter owns one transaction at a time. For a fill it issues the 8 word addresses back-to-back, routes returning data-valid strobes to the owner with a word index, and pulses done on completion. It sits between the two cache fill FSMs and the memory model.

## Interface
Parameters:
- none (block size 8 words, memory latency 4 are fixed)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  I-side request; held until i_done
- i_wr  in  1  I-side request type: 1 = single-word write, 0 = block fill
- i_addr  in  16  I-side byte address
- i_wdata  in  16  I-side write data
- d_req, d_wr, d_addr, d_wdata  in  1/1/16/16  D-side equivalents
- mem_data_valid  in  1  memory read-data strobe (word arrives 4 cycles after its issue)
- mem_enable  out  1  memory access this cycle
- mem_wr  out  1  access is a write
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- i_grant, d_grant  out  1  level; high for the whole owned transaction
- i_data_valid, d_data_valid  out  1  mem_data_valid gated to the current fill owner
- word_idx  out  3  index of the word currently returning (0..7)
- i_done, d_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, FILL, WRITE.
- IDLE:
  - Arbitrate among active requests.
  - The winner is latched: owner, type, address, write data.
  - Next state is FILL or WRITE, and the owner's grant rises on that edge.
- FILL:
  - Base address = {addr[15:4], 4'h0}.
  - Issue counter 0..7: mem_enable=1, mem_wr=0, mem_addr = base + 2*issue_cnt, one address per cycle for 8 consecutive cycles. mem_enable=0 after the 8th issue.
  - Return counter 0..7 advances on each mem_data_valid. word_idx = return counter. The owner's x_data_valid = mem_data_valid.
  - On the 8th return, the state goes to IDLE.
- WRITE:
  - One cycle: mem_enable=1, mem_wr=1, mem_addr = latched addr with bit0 forced to 0, mem_wdata = latched data.
  - The state then goes to IDLE.
- Done pulse:
  - x_done is asserted for one cycle in the first IDLE cycle after the transaction ends.
  - Grant drops on that same edge.
  - During the done cycle, the just-completed requester's req is ignored for arbitration. The other requester may win in that cycle.
- Requests that drop mid-transaction do not abort it. An in-flight fill always completes all 8 returns.
- mem_data_valid in IDLE or WRITE is ignored: no x_data_valid and no counter change.
- Counters wrap-free: 3-bit counters. Address adds are 16-bit with carry discarded, so base 16'hFFF0 issues FFF0..FFFE.

## Timing
- Reset values: mem_enable=0, mem_wr=0, mem_addr=0, mem_wdata=0, grants=0, data_valids=0, word_idx=0, dones=0. State = IDLE, counters = 0, round-robin pointer = "D last served".
- Reset asserted mid-transaction: return to IDLE immediately (asynchronous). Memory data still in flight is dropped as stray strobes.
- Fill latency, with request seen at cycle 0:
  - Grant and first issue at cycle 1; issues at cycles 1..8.
  - Returns at cycles 5..12.
  - Done at cycle 13; the next grant can occur at cycle 14.
- Write latency: request at cycle 0, write at cycle 1, done at cycle 2.
- Outputs mem_* and grant/done are registered or decoded from registered state only. x_data_valid and word_idx are combinational from mem_data_valid and owner.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN:
  - Defined: a 1-bit pointer records the last-served requester. With both requests pending, the requester not last served wins. After reset the I side wins the first tie.
  - Undefined: fixed priority, D side always wins a tie, and the pointer logic is absent.

## Test plan
- I fill alone, i_addr=16'h1236 at cycle 0:
  - mem_addr 1230,1232,...,123E at cycles 1..8.
  - Memory returns words at cycles 5..12: i_data_valid with word_idx 0..7.
  - i_done at cycle 13; d_grant never rises.
- i_req and d_req (both fills) in the same IDLE cycle after reset:
  - Round-robin defined: I served first, D granted at cycle 14.
  - Undefined: D served first.
- D write, d_addr=16'h4001, d_wdata=16'hBEEF:
  - Cycle 1: mem_enable=1, mem_wr=1, mem_addr=16'h4000, mem_wdata=16'hBEEF.
  - Cycle 2: d_done.
- rst_n low at cycle 6 of an I fill:
  - All outputs are 0 immediately.
  - After release, stray mem_data_valid strobes produce no i_data_valid.
  - A new d_req is then granted normally.
- Back-to-back I fills with i_req held continuously:
  - The request is ignored during the done cycle.
  - The second grant comes one cycle later.
- Fill at 16'hFFF8: addresses FFF0..FFFE, no wrap into 0000.
